spindle_rate_to_spike: RTL and testbench

//  Rate-to-spike encoder for spindle afferents: converts an IEEE-754 float32 firing rate (pps, Ia or II)

---
 rtl/spindle_spike_pkg.sv | 20 ++
 rtl/spindle_rate_to_spike_f32_to_ufix_rate.sv | 37 +++
 rtl/spindle_rate_to_spike.sv | 168 ++++++++++++++++
 tb/tb_spindle_rate_to_spike.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/spindle_spike_pkg.sv
// Shared constants and types for the spindle rate-to-spike encoder.
package spindle_spike_pkg;

    localparam logic [31:0] IEEE_100000 = 32'h47C3_5000;
    localparam int          FRAC_BITS   = 8;
    localparam logic [24:0] RATE_FX_MAX = 25'd25_600_000;

    typedef logic [0:0] state_t;
    localparam state_t IDLE  = 1'b0;
    localparam state_t DRAIN = 1'b1;

    // x^8+x^6+x^5+x^4+1: feedback taps are register bits 7,5,4,3
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/spindle_rate_to_spike_f32_to_ufix_rate.sv
// Combinational float32 pps -> unsigned Q17.8 converter; negatives, NaN and tiny values give 0,
// +inf and anything above 100000.0 clamp to RATE_FX_MAX.
module f32_to_ufix_rate
    import spindle_spike_pkg::*;
(
    input  logic [31:0] f_in,
    output logic [24:0] fx_out
);

    logic        sgn;
    logic [7:0]  expo;
    logic [22:0] mant;
    logic [4:0]  shamt;

    assign sgn  = f_in[31];
    assign expo = f_in[30:23];
    assign mant = f_in[22:0];

    // Significand placed one bit up so exp==143 (65536..100000) needs no left shift
    assign shamt = 5'(8'd143 - expo);

    always_comb begin
        fx_out = '0;
        if (sgn || expo == 8'd0) begin
            fx_out = '0;
        end else if (expo == 8'hFF) begin
            fx_out = (mant != '0) ? 25'd0 : RATE_FX_MAX;
        end else if (f_in > IEEE_100000) begin
            fx_out = RATE_FX_MAX;
        end else if (expo < 8'd119) begin
            fx_out = '0;
        end else begin
            fx_out = {1'b1, mant, 1'b0} >> shamt;
        end
    end

endmodule

// File: rtl/spindle_rate_to_spike.sv
// Float32 rate -> spike train via a Q.8 phase accumulator; tick-to-spike latency 3 cycles, pending spikes saturate.
// Define SPINDLE_SPIKE_DITHER_EN to add zero-mean LFSR dither to every accumulate.
module spindle_rate_to_spike
    import spindle_spike_pkg::*;
#(
    parameter int TICK_HZ   = 1000,
    parameter int SPIKE_GAP = 4,
    parameter int PEND_MAX  = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] rate_in,
    input  logic        rate_valid,
    input  logic        tick,
    output logic        spike,
    output logic [31:0] spike_cnt,
    output logic        pend_ovf,
    output logic        tick_ovr,
    output logic        busy
);

    localparam logic [31:0] THRESH = 32'(TICK_HZ) << FRAC_BITS;
    localparam int          GAP_W  = $clog2(SPIKE_GAP + 1);
    localparam logic [GAP_W-1:0] GAP_LD  = GAP_W'(SPIKE_GAP);
    localparam logic [7:0]       PEND_SAT = 8'(PEND_MAX);

    logic [24:0]      rate_fx_conv;
    logic [24:0]      rate_fx_d, rate_fx_q;
    logic [31:0]      acc_d, acc_q;
    logic [31:0]      acc_sum;
    logic [7:0]       pend_d, pend_q;
    logic [GAP_W-1:0] gap_d, gap_q;
    state_t           state_d, state_q;
    logic             tick_lat_d, tick_lat_q;
    logic             spike_d, spike_q;
    logic [31:0]      spike_cnt_d, spike_cnt_q;
    logic             pend_ovf_d, pend_ovf_q;
    logic             tick_ovr_d, tick_ovr_q;
    logic             tick_any;
    logic             accum;
    logic             pend_inc;
    logic             emit;

    f32_to_ufix_rate u_conv (
        .f_in   (rate_in),
        .fx_out (rate_fx_conv)
    );

    assign tick_any = tick | tick_lat_q;
    assign accum    = (state_q == IDLE) && tick_any;

`ifdef SPINDLE_SPIKE_DITHER_EN
    logic [7:0] lfsr_d, lfsr_q;

    // LFSR never reaches 0, so values 1..255 minus 128 average to zero
    always_comb begin
        lfsr_d  = accum ? lfsr_step(lfsr_q) : lfsr_q;
        acc_sum = acc_q + {7'd0, rate_fx_q} + {24'd0, lfsr_q};
        acc_sum = (acc_sum >= 32'd128) ? (acc_sum - 32'd128) : 32'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    always_comb begin
        acc_sum = acc_q + {7'd0, rate_fx_q};
    end
`endif

    always_comb begin
        rate_fx_d  = rate_valid ? rate_fx_conv : rate_fx_q;
        acc_d      = acc_q;
        state_d    = state_q;
        tick_lat_d = tick_lat_q;
        tick_ovr_d = tick_ovr_q;
        pend_inc   = 1'b0;

        if (state_q == IDLE) begin
            if (tick_any) begin
                acc_d      = acc_sum;
                tick_lat_d = 1'b0;
                state_d    = DRAIN;
                if (tick && tick_lat_q) begin
                    tick_ovr_d = 1'b1;
                end
            end
        end else begin
            if (acc_q >= THRESH) begin
                acc_d    = acc_q - THRESH;
                pend_inc = 1'b1;
            end else begin
                state_d = IDLE;
            end
            if (tick) begin
                if (tick_lat_q) begin
                    tick_ovr_d = 1'b1;
                end else begin
                    tick_lat_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        emit        = (pend_q != 8'd0) && (gap_q == '0);
        spike_d     = emit;
        spike_cnt_d = spike_cnt_q + {31'd0, emit};
        pend_d      = pend_q;
        pend_ovf_d  = pend_ovf_q;

        if (emit) begin
            gap_d = GAP_LD;
        end else if (gap_q != '0) begin
            gap_d = gap_q - GAP_W'(1);
        end else begin
            gap_d = gap_q;
        end

        // A drain increment and an emit decrement in the same cycle cancel out
        if (pend_inc && !emit) begin
            if (pend_q == PEND_SAT) begin
                pend_ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + 8'd1;
            end
        end else if (!pend_inc && emit) begin
            pend_d = pend_q - 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rate_fx_q   <= '0;
            acc_q       <= '0;
            pend_q      <= '0;
            gap_q       <= '0;
            state_q     <= IDLE;
            tick_lat_q  <= 1'b0;
            spike_q     <= 1'b0;
            spike_cnt_q <= '0;
            pend_ovf_q  <= 1'b0;
            tick_ovr_q  <= 1'b0;
        end else begin
            rate_fx_q   <= rate_fx_d;
            acc_q       <= acc_d;
            pend_q      <= pend_d;
            gap_q       <= gap_d;
            state_q     <= state_d;
            tick_lat_q  <= tick_lat_d;
            spike_q     <= spike_d;
            spike_cnt_q <= spike_cnt_d;
            pend_ovf_q  <= pend_ovf_d;
            tick_ovr_q  <= tick_ovr_d;
        end
    end

    assign spike     = spike_q;
    assign spike_cnt = spike_cnt_q;
    assign pend_ovf  = pend_ovf_q;
    assign tick_ovr  = tick_ovr_q;
    assign busy      = (state_q != IDLE) || (pend_q != 8'd0);

endmodule

// File: tb/tb_spindle_rate_to_spike.sv
// Directed bench: expected spike cycles are queued per tick and matched by a negedge monitor.
module tb_spindle_rate_to_spike;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] rate_in;
    logic        rate_valid;
    logic        tick;
    logic        tick_b;
    logic        spike, pend_ovf, tick_ovr, busy;
    logic [31:0] spike_cnt;
    logic        spike_b, pend_ovf_b, tick_ovr_b, busy_b;
    logic [31:0] spike_cnt_b;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int exp_q[$];
    int e_cyc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spindle_rate_to_spike #(.TICK_HZ(1000), .SPIKE_GAP(4), .PEND_MAX(255)) dut (
        .clk(clk), .reset(reset), .rate_in(rate_in), .rate_valid(rate_valid), .tick(tick),
        .spike(spike), .spike_cnt(spike_cnt), .pend_ovf(pend_ovf), .tick_ovr(tick_ovr), .busy(busy)
    );

    spindle_rate_to_spike #(.TICK_HZ(1000), .SPIKE_GAP(1000), .PEND_MAX(255)) dut_gap (
        .clk(clk), .reset(reset), .rate_in(rate_in), .rate_valid(rate_valid), .tick(tick_b),
        .spike(spike_b), .spike_cnt(spike_cnt_b), .pend_ovf(pend_ovf_b), .tick_ovr(tick_ovr_b),
        .busy(busy_b)
    );

    // Scoreboard monitor: every spike must match the head of the expected-cycle queue
    always @(negedge clk) begin
        if (!reset && spike) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL spike_unexpected at cycle %0d, required none", cyc);
            end else begin
                e_cyc = exp_q.pop_front();
                if (e_cyc != cyc) begin
                    errors++;
                    $display("FAIL spike_time got cycle %0d, required %0d", cyc, e_cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic load_rate(input logic [31:0] v);
        @(posedge clk); #1;
        rate_in    = v;
        rate_valid = 1'b1;
        @(posedge clk); #1;
        rate_valid = 1'b0;
    endtask

    // Tick during cycle t; nsp spikes expected at t+3, t+8, ... (gap of 4 -> 5-cycle spacing)
    task automatic do_tick(input int nsp);
        int t;
        @(posedge clk); #1;
        tick = 1'b1;
        t = cyc;
        for (int k = 0; k < nsp; k++) exp_q.push_back(t + 3 + 5 * k);
        @(posedge clk); #1;
        tick = 1'b0;
    endtask

    task automatic do_tick_b();
        @(posedge clk); #1;
        tick_b = 1'b1;
        @(posedge clk); #1;
        tick_b = 1'b0;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        rate_in    = '0;
        rate_valid = 1'b0;
        tick       = 1'b0;
        tick_b     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_spike", {31'd0, spike}, 32'd0);
        chk("reset_spike_cnt", spike_cnt, 32'd0);
        chk("reset_pend_ovf", {31'd0, pend_ovf}, 32'd0);
        chk("reset_tick_ovr", {31'd0, tick_ovr}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;

        // 1000 pps: exactly one threshold per tick
        load_rate(32'h447A_0000);
        for (int i = 0; i < 10; i++) begin
            do_tick(1);
            wait_cyc(198);
        end
        chk("t1_spike_cnt", spike_cnt, 32'd10);
        chk("t1_queue_left", exp_q.size(), 32'd0);

        // 500 pps: spike on every second tick
        apply_reset();
        load_rate(32'h43FA_0000);
        for (int i = 1; i <= 10; i++) begin
            do_tick((i % 2 == 0) ? 1 : 0);
            wait_cyc(198);
        end
        chk("t2_spike_cnt", spike_cnt, 32'd5);
        chk("t2_queue_left", exp_q.size(), 32'd0);

        // Negative and NaN give nothing; +inf clamps to 100 spikes per tick
        apply_reset();
        load_rate(32'hC0A0_0000);
        for (int i = 0; i < 5; i++) begin
            do_tick(0);
            wait_cyc(20);
        end
        load_rate(32'h7FC0_0000);
        for (int i = 0; i < 5; i++) begin
            do_tick(0);
            wait_cyc(20);
        end
        chk("t3_zero_rate_cnt", spike_cnt, 32'd0);
        load_rate(32'h7F80_0000);
        do_tick(100);
        wait_cyc(600);
        chk("t3_inf_spike_cnt", spike_cnt, 32'd100);
        chk("t3_queue_left", exp_q.size(), 32'd0);
        chk("t3_busy_idle", {31'd0, busy}, 32'd0);

        // Long gap: pending saturates at 255 on the third tick
        apply_reset();
        load_rate(32'h47C3_5000);
        do_tick_b();
        wait_cyc(199);
        do_tick_b();
        wait_cyc(190);
        chk("t4_ovf_before", {31'd0, pend_ovf_b}, 32'd0);
        wait_cyc(9);
        do_tick_b();
        wait_cyc(150);
        chk("t4_ovf_set", {31'd0, pend_ovf_b}, 32'd1);
        wait_cyc(300);
        chk("t4_ovf_sticky", {31'd0, pend_ovf_b}, 32'd1);
        chk("t4_spike_cnt", spike_cnt_b, 32'd1);
        chk("t4_busy", {31'd0, busy_b}, 32'd1);

        // Tick latch: one extra tick kept, a second one dropped
        apply_reset();
        load_rate(32'h47C3_5000);
        do_tick(200);
        chk("t5_ovr_clear", {31'd0, tick_ovr}, 32'd0);
        wait_cyc(9);
        do_tick(0);
        wait_cyc(9);
        do_tick(0);
        chk("t5_ovr_set", {31'd0, tick_ovr}, 32'd1);
        wait_cyc(1000);
        chk("t5_spike_cnt", spike_cnt, 32'd200);
        chk("t5_queue_left", exp_q.size(), 32'd0);
        chk("t5_pend_ovf", {31'd0, pend_ovf}, 32'd0);

        // Reset mid-drain with 40 pending spikes
        apply_reset();
        load_rate(32'h7F80_0000);
        do_tick(10);
        wait_cyc(50);
        chk("t6_busy_before", {31'd0, busy}, 32'd1);
        chk("t6_cnt_before", spike_cnt, 32'd10);
        chk("t6_queue_left", exp_q.size(), 32'd0);
        reset = 1'b1;
        #1;
        chk("t6_spike_rst", {31'd0, spike}, 32'd0);
        chk("t6_cnt_rst", spike_cnt, 32'd0);
        chk("t6_busy_rst", {31'd0, busy}, 32'd0);
        wait_cyc(2);
        reset = 1'b0;
        wait_cyc(300);
        chk("t6_cnt_after", spike_cnt, 32'd0);
        chk("t6_busy_after", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
